// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS-subset core: sequences each instruction
// through fetch/decode/execute/memory/writeback and drives datapath selects and strobes.
module multicycle_control (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] Op,
    input  logic       MemReady,
    input  logic       Zero,
    output logic [2:0] UCon,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       BadOp,
    output logic       Done,
    output logic [3:0] State
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXEC   = 4'd6,
        ALUWB  = 4'd7,
        BRANCH = 4'd8,
        IEXEC  = 4'd9,
        IWB    = 4'd10,
        JUMP   = 4'd11
    } state_t;

    state_t     state, state_next;
    logic [2:0] imm_code, imm_code_next;
    logic       bad_op, bad_op_next;

    // Zero is applied in the datapath through PCWriteCond; the FSM never branches on it.
    logic unused_zero;
    assign unused_zero = Zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= FETCH;
            imm_code <= '0;
            bad_op   <= 1'b0;
        end else begin
            state  <= state_next;
            bad_op <= bad_op_next;
            if (state == DECODE)
                imm_code <= imm_code_next;
        end
    end

    always_comb begin
        state_next    = FETCH;
        bad_op_next   = 1'b0;
        imm_code_next = 3'b000;
        case (Op)
            OP_ADDI: imm_code_next = 3'b011;
            OP_ANDI: imm_code_next = 3'b100;
            OP_ORI:  imm_code_next = 3'b101;
            OP_SLTI: imm_code_next = 3'b110;
            default: imm_code_next = 3'b000;
        endcase
        case (state)
            FETCH:  state_next = MemReady ? DECODE : FETCH;
            DECODE: begin
                case (Op)
                    OP_LW, OP_SW:                     state_next = MEMADR;
                    OP_R:                             state_next = EXEC;
                    OP_BEQ:                           state_next = BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_next = IEXEC;
                    OP_J:                             state_next = JUMP;
                    default: begin
                        state_next  = FETCH;
                        bad_op_next = 1'b1;
                    end
                endcase
            end
            MEMADR: state_next = (Op == OP_SW) ? MEMWR : MEMRD;
            MEMRD:  state_next = MemReady ? MEMWB : MEMRD;
            MEMWB:  state_next = FETCH;
            MEMWR:  state_next = MemReady ? FETCH : MEMWR;
            EXEC:   state_next = ALUWB;
            ALUWB:  state_next = FETCH;
            BRANCH: state_next = FETCH;
            IEXEC:  state_next = IWB;
            IWB:    state_next = FETCH;
            JUMP:   state_next = FETCH;
            default: state_next = FETCH;
        endcase
    end

    always_comb begin
        UCon        = 3'b000;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        Done        = 1'b0;
        BadOp       = bad_op;
        State       = state;
        case (state)
            FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = MemReady;
                PCWrite = MemReady;
            end
            DECODE: ALUSrcB = 2'b11;
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            MEMRD: begin
                IorD    = 1'b1;
                MemRead = 1'b1;
            end
            MEMWB: begin
                MemtoReg = 1'b1;
                RegWrite = 1'b1;
                Done     = 1'b1;
            end
            MEMWR: begin
                IorD     = 1'b1;
                MemWrite = 1'b1;
                Done     = MemReady;
            end
            EXEC: begin
                ALUSrcA = 1'b1;
                UCon    = 3'b010;
            end
            ALUWB: begin
                RegDst   = 1'b1;
                RegWrite = 1'b1;
                Done     = 1'b1;
            end
            BRANCH: begin
                ALUSrcA     = 1'b1;
                UCon        = 3'b001;
                PCSource    = 2'b01;
                PCWriteCond = 1'b1;
                Done        = 1'b1;
            end
            IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                UCon    = imm_code;
            end
            IWB: begin
                UCon     = imm_code;
                RegWrite = 1'b1;
                Done     = 1'b1;
            end
            JUMP: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                Done     = 1'b1;
            end
            default: ;
        endcase
        // Reset silences every output, including the debug state and the registered BadOp.
        if (rst) begin
            UCon        = '0;
            ALUSrcA     = 1'b0;
            ALUSrcB     = '0;
            PCSource    = '0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            RegDst      = 1'b0;
            MemtoReg    = 1'b0;
            Done        = 1'b0;
            BadOp       = 1'b0;
            State       = '0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: a per-instruction model expands each
// instruction into its expected cycle-by-cycle output trace and compares every cycle.
module tb_multicycle_control;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    typedef struct packed {
        logic [3:0] state;
        logic [2:0] ucon;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic [1:0] pcsource;
        logic       pcwrite;
        logic       pcwritecond;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       regwrite;
        logic       regdst;
        logic       memtoreg;
        logic       badop;
        logic       done;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       ready;
        outs_t      o;
    } cyc_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] Op = '0;
    logic       MemReady = 1'b0;
    logic       Zero = 1'b0;
    logic [2:0] UCon;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegWrite, RegDst, MemtoReg, BadOp, Done;
    logic [3:0] State;

    outs_t obs;
    cyc_t  q[$];
    int    checks = 0;
    int    fails = 0;
    bit    pending_bad = 0;
    string tag = "";

    multicycle_control dut (
        .clk(clk), .rst(rst), .Op(Op), .MemReady(MemReady), .Zero(Zero),
        .UCon(UCon), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .PCSource(PCSource),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .BadOp(BadOp), .Done(Done), .State(State)
    );

    always #5 clk = ~clk;

    assign obs = {State, UCon, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD,
                  MemRead, MemWrite, IRWrite, RegWrite, RegDst, MemtoReg, BadOp, Done};

    function automatic bit supported(logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
    endfunction

    function automatic logic [2:0] imm_ucon(logic [5:0] op);
        case (op)
            OP_ADDI: return 3'b011;
            OP_ANDI: return 3'b100;
            OP_ORI:  return 3'b101;
            default: return 3'b110;
        endcase
    endfunction

    function automatic void push(logic [5:0] op, logic ready, outs_t o);
        cyc_t c;
        c.op = op;
        c.ready = ready;
        c.o = o;
        q.push_back(c);
    endfunction

    // Expand one instruction: fw/mw are wait cycles in fetch and in the data-memory
    // phase; after is the opcode presented once decode is over (ignored for lw/sw).
    function automatic void build(logic [5:0] op, int unsigned fw, int unsigned mw, logic [5:0] after);
        outs_t      o;
        logic [5:0] d;
        for (int unsigned i = 0; i <= fw; i++) begin
            o = '0;
            o.memread = 1'b1;
            o.alusrcb = 2'b01;
            o.irwrite = (i == fw);
            o.pcwrite = (i == fw);
            o.badop   = pending_bad && (i == 0);
            push(6'($urandom), (i == fw), o);
        end
        pending_bad = 0;
        o = '0;
        o.state = 4'd1;
        o.alusrcb = 2'b11;
        push(op, 1'($urandom), o);
        d = (op == OP_LW || op == OP_SW) ? op : after;
        case (op)
            OP_LW, OP_SW: begin
                o = '0;
                o.state = 4'd2; o.alusrca = 1'b1; o.alusrcb = 2'b10;
                push(d, 1'($urandom), o);
                for (int unsigned i = 0; i <= mw; i++) begin
                    o = '0;
                    o.iord = 1'b1;
                    if (op == OP_LW) begin
                        o.state = 4'd3; o.memread = 1'b1;
                    end else begin
                        o.state = 4'd5; o.memwrite = 1'b1; o.done = (i == mw);
                    end
                    push(d, (i == mw), o);
                end
                if (op == OP_LW) begin
                    o = '0;
                    o.state = 4'd4; o.memtoreg = 1'b1; o.regwrite = 1'b1; o.done = 1'b1;
                    push(d, 1'($urandom), o);
                end
            end
            OP_R: begin
                o = '0;
                o.state = 4'd6; o.alusrca = 1'b1; o.ucon = 3'b010;
                push(d, 1'($urandom), o);
                o = '0;
                o.state = 4'd7; o.regdst = 1'b1; o.regwrite = 1'b1; o.done = 1'b1;
                push(d, 1'($urandom), o);
            end
            OP_BEQ: begin
                o = '0;
                o.state = 4'd8; o.alusrca = 1'b1; o.ucon = 3'b001; o.pcsource = 2'b01;
                o.pcwritecond = 1'b1; o.done = 1'b1;
                push(d, 1'($urandom), o);
            end
            OP_J: begin
                o = '0;
                o.state = 4'd11; o.pcsource = 2'b10; o.pcwrite = 1'b1; o.done = 1'b1;
                push(d, 1'($urandom), o);
            end
            OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: begin
                o = '0;
                o.state = 4'd9; o.alusrca = 1'b1; o.alusrcb = 2'b10; o.ucon = imm_ucon(op);
                push(d, 1'($urandom), o);
                o = '0;
                o.state = 4'd10; o.ucon = imm_ucon(op); o.regwrite = 1'b1; o.done = 1'b1;
                push(d, 1'($urandom), o);
            end
            default: pending_bad = 1;
        endcase
    endfunction

    // Entered and left just after a rising edge; drives one cycle and checks it at the falling edge.
    task automatic run_n(input int n);
        cyc_t c;
        for (int k = 0; k < n && q.size() > 0; k++) begin
            c = q.pop_front();
            Op = c.op;
            MemReady = c.ready;
            @(negedge clk);
            checks++;
            if (obs !== c.o) begin
                fails++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, k, obs, c.o);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset;
        tag = "reset";
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (obs !== outs_t'('0)) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, obs, outs_t'('0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pending_bad = 0;
    endtask

    task automatic test_lw;
        tag = "lw";
        build(OP_LW, 0, 0, OP_LW);
        run_n(q.size());
    endtask

    task automatic test_r_then_ori;
        tag = "r_then_ori";
        build(OP_R, 0, 0, 6'($urandom));
        build(OP_ORI, 0, 0, OP_R);
        run_n(q.size());
    endtask

    task automatic test_sw_wait;
        tag = "sw_wait";
        build(OP_SW, 0, 3, OP_SW);
        run_n(q.size());
    endtask

    task automatic test_beq_j;
        tag = "beq_j";
        build(OP_BEQ, 0, 0, OP_BEQ);
        build(OP_J, 0, 0, OP_J);
        run_n(q.size());
    endtask

    task automatic test_badop;
        tag = "badop";
        build(6'b111111, 0, 0, 6'b111111);
        build(OP_J, 1, 0, OP_J);
        run_n(q.size());
    endtask

    task automatic test_mid_reset;
        tag = "mid_reset";
        build(OP_LW, 0, 3, OP_LW);
        run_n(4);
        q.delete();
        MemReady = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== outs_t'('0)) begin
            fails++;
            $display("FAIL %s forced: got %h expected %h", tag, obs, outs_t'('0));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        pending_bad = 0;
        tag = "after_reset";
        build(OP_ADDI, 0, 0, 6'($urandom));
        run_n(q.size());
    endtask

    task automatic test_random;
        logic [5:0] ops[9] = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI};
        logic [5:0] op;
        tag = "random";
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                op = 6'($urandom);
                while (supported(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(0, 8)];
            end
            build(op, $urandom_range(0, 3), $urandom_range(0, 3), 6'($urandom));
        end
        build(OP_BEQ, 0, 0, 6'($urandom));
        run_n(q.size());
    endtask

    initial begin
        test_reset();
        test_lw();
        test_r_then_ori();
        test_sw_wait();
        test_beq_j();
        test_badop();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle MIPS-subset core. It sequences one instruction over 3–5 cycles through the shared ALU, memory and register file, and it stalls on the memory ready handshake. It drives the 3-bit `UCon` code consumed by `ALUControl`, which turns that code plus the funct field into `ALUSelect`. It also drives all datapath mux selects and write strobes.

## Interface
Parameters: none (opcode and state encodings fixed below).

Ports:
- `clk`  in  1  single clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `Op`  in  6  opcode field, instr[31:26], from IR
- `MemReady`  in  1  memory completed current read/write this cycle
- `Zero`  in  1  ALU zero flag; passed through via `PCWriteCond` gating in datapath
- `UCon`  out  3  ALU op code to `ALUControl`
- `ALUSrcA`  out  1  0 = PC, 1 = regA
- `ALUSrcB`  out  2  00 = regB, 01 = const 4, 10 = sign-ext imm, 11 = imm<<2
- `PCSource`  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegWrite`, `RegDst`, `MemtoReg`  out  1 each  datapath strobes/selects
- `BadOp`  out  1  one-cycle pulse, unsupported opcode decoded
- `Done`  out  1  one-cycle pulse, instruction retired (last state before FETCH)
- `State`  out  4  current state, for debug

## Operation
- Opcodes: R 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000, andi 001100, ori 001101, slti 001010.
- `UCon` codes: 000 add (lw/sw/PC), 001 sub (beq), 010 R-type funct, 011 addi, 100 andi, 101 ori, 110 slti.
- State encodings and transitions:
  - FETCH (0) → DECODE once `MemReady`; otherwise hold.
  - DECODE (1):
    - → MEMADR for lw/sw.
    - → EXEC for R-type.
    - → BRANCH for beq.
    - → IEXEC for immediate ops.
    - → JUMP for j.
    - Any other opcode → FETCH with `BadOp` = 1.
  - MEMADR (2) → MEMRD for lw, MEMWR for sw.
  - MEMRD (3) → MEMWB on `MemReady`; otherwise hold.
  - MEMWB (4) → FETCH.
  - MEMWR (5) → FETCH on `MemReady`; otherwise hold.
  - EXEC (6) → ALUWB → FETCH.
  - BRANCH (8) → FETCH.
  - IEXEC (9) → IWB (10) → FETCH.
  - JUMP (11) → FETCH.
  - Encodings 7 is ALUWB; 12–15 are illegal and go → FETCH.
- Moore outputs. Every output not listed for a state is 0.
  - FETCH: `MemRead`=1, `ALUSrcB`=01, `UCon`=000; `IRWrite` = `PCWrite` = `MemReady`.
  - DECODE: `ALUSrcB`=11, `UCon`=000.
  - MEMADR: `ALUSrcA`=1, `ALUSrcB`=10, `UCon`=000.
  - MEMRD: `IorD`=1, `MemRead`=1.
  - MEMWB: `MemtoReg`=1, `RegWrite`=1, `Done`=1.
  - MEMWR: `IorD`=1, `MemWrite`=1; `Done` = `MemReady`.
  - EXEC: `ALUSrcA`=1, `UCon`=010.
  - ALUWB: `RegDst`=1, `RegWrite`=1, `Done`=1.
  - BRANCH: `ALUSrcA`=1, `UCon`=001, `PCSource`=01, `PCWriteCond`=1, `Done`=1.
  - IEXEC: `ALUSrcA`=1, `ALUSrcB`=10, `UCon` = latched immediate code.
  - IWB: `UCon` = latched immediate code, `RegWrite`=1, `Done`=1.
  - JUMP: `PCSource`=10, `PCWrite`=1, `Done`=1.
- Immediate code (011/100/101/110) is registered in DECODE from `Op`. It stays stable through IEXEC/IWB even if `Op` changes.
- `BadOp` is registered; it is high for the single FETCH cycle following DECODE.

## Timing
- Reset:
  - `rst` high at an edge → State = FETCH (0), latched code = 000, `BadOp` = 0.
  - While `rst` is high, all outputs are forced 0 (including `MemRead`, `State`).
- Reset mid-instruction aborts it with no further strobes. FETCH restarts on the first edge after `rst` falls.
- Latency with `MemReady` tied high:
  - R-type, addi/andi/ori/slti, sw: 4 cycles.
  - lw: 5 cycles.
  - beq, j: 3 cycles.
  - Each low-`MemReady` cycle in FETCH/MEMRD/MEMWR adds one cycle. Strobes stay asserted while waiting.
- `RegWrite` and `MemWrite` are each high for exactly one cycle per instruction (`MemWrite`: the cycles until and including ready).
- `Done` occurs exactly once per retired instruction; it is never asserted for `BadOp`.

## Test plan
- Reset: assert `rst` in MEMRD (State=3) → next cycle all outputs 0. After release, first cycle State=0 with `MemRead`=1.
- lw, `MemReady`=1: State sequence 0,1,2,3,4,0. `UCon` is 000 in states 0–2. `RegWrite`=`MemtoReg`=1 only in state 4. `Done` pulses once.
- R-type then ori: R-type gives `UCon`=010 in EXEC and `RegDst`=1 in ALUWB. ori gives `UCon`=101 in both IEXEC and IWB, even with `Op` changed to 000000 after DECODE.
- sw with `MemReady` low for 3 cycles in MEMWR: `MemWrite`=1 for 4 cycles, `Done` on the 4th, then FETCH.
- beq: 0,1,8,0 with `UCon`=001, `PCWriteCond`=1, `PCSource`=01 in state 8. j: `PCSource`=10, `PCWrite`=1 in state 11.
- `Op`=111111: DECODE → FETCH, `BadOp`=1 for one cycle, no `RegWrite`/`MemWrite`/`Done`.
